// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the data-side memory access controller: RV32I load/store
// funct3 widths, controller FSM states and the busy-line levels.
package mem_access_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic MEM_BUSY     = 1'b1;
  localparam logic MEM_NOT_BUSY = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP,
    ST_FAULT
  } state_e;

  // Unsigned widths only exist for loads; halfwords need even, words 4-aligned addresses.
  function automatic logic accessIllegal(input logic isStore, input logic [2:0] funct3,
                                         input logic [1:0] addrLo);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_LB:   bad = 1'b0;
      F3_LH:   bad = addrLo[0];
      F3_LW:   bad = (addrLo != 2'b00);
      F3_LBU:  bad = isStore;
      F3_LHU:  bad = isStore | addrLo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Load formatting: picks the addressed byte/halfword lane out of a RAM word and
// sign- or zero-extends it to 32 bits according to the load funct3.
module mem_access_ctrl_load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = word_i[{addr_lo_i, 3'b000} +: 8];
    halfSel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{byteSel[7]}}, byteSel};
      F3_LH:   data_o = {{16{halfSel[15]}}, halfSel};
      F3_LBU:  data_o = {24'h000000, byteSel};
      F3_LHU:  data_o = {16'h0000, halfSel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-side memory access controller: accepts one load/store, waits WAIT_STATES
// cycles, strobes a synchronous word RAM once and returns formatted load data.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [31:0]           byte_addr_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  input  logic                  mwr_i,
  input  logic                  mrd_i,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  mem_busy_o,
  output logic                  mem_rdy_o,
  output logic                  fault_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wd_o,
  output logic [3:0]            ram_be_o,
  output logic                  ram_we_o,
  output logic                  ram_re_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_i
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [3:0]            waitCnt_q, waitCnt_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  isStore_q, isStore_d;

  logic [DATA_WIDTH-1:0] loadData;
  logic [DATA_WIDTH-1:0] storeWd;
  logic [3:0]            storeBe;
  logic                  unusedAddrBits;

  assign unusedAddrBits = ^byte_addr_i[31:ADDR_WIDTH+2];

  mem_access_ctrl_load_extend u_load_extend (
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .word_i    (ram_rd_i),
    .data_o    (loadData)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= 4'd0;
      addr_q    <= '0;
      funct3_q  <= 3'b000;
      wd_q      <= '0;
      rd_q      <= '0;
      isStore_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      addr_q    <= addr_d;
      funct3_q  <= funct3_d;
      wd_q      <= wd_d;
      rd_q      <= rd_d;
      isStore_q <= isStore_d;
    end
  end

  // A store wins when both request lines are raised; rejected accesses skip the RAM entirely.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    wd_d      = wd_q;
    rd_d      = rd_q;
    isStore_d = isStore_q;
    case (state_q)
      ST_IDLE: begin
        if (mrd_i | mwr_i) begin
          addr_d    = byte_addr_i[ADDR_WIDTH+1:0];
          funct3_d  = funct3_i;
          wd_d      = wd_i;
          isStore_d = mwr_i;
          if (accessIllegal(mwr_i, funct3_i, byte_addr_i[1:0])) begin
            state_d = ST_FAULT;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d   = ST_WAIT;
            waitCnt_d = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        waitCnt_d = waitCnt_q - 4'd1;
        if (waitCnt_q <= 4'd1) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        if (!isStore_q) begin
          rd_d = loadData;
        end
        state_d = ST_IDLE;
      end
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Store data is replicated across every lane so the byte enables alone pick the target bytes.
  always_comb begin
    storeBe = 4'b1111;
    storeWd = wd_q;
    case (funct3_q[1:0])
      2'b00: begin
        storeBe = 4'b0001 << addr_q[1:0];
        storeWd = {4{wd_q[7:0]}};
      end
      2'b01: begin
        storeBe = addr_q[1] ? 4'b1100 : 4'b0011;
        storeWd = {2{wd_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign ram_we_o   = (state_q == ST_ACCESS) &  isStore_q;
  assign ram_re_o   = (state_q == ST_ACCESS) & ~isStore_q;
  assign ram_be_o   = ram_we_o ? storeBe : 4'b0000;
  assign ram_wd_o   = storeWd;
  assign ram_addr_o = addr_q[ADDR_WIDTH+1:2];
  assign mem_busy_o = (state_q != ST_IDLE) ? MEM_BUSY : MEM_NOT_BUSY;
  assign mem_rdy_o  = (state_q == ST_RESP) | (state_q == ST_FAULT);
  assign fault_o    = (state_q == ST_FAULT);
  assign rd_o       = rd_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed loads, stores, faults and resets
// on a WAIT_STATES=2 instance, plus streaming throughput on a WAIT_STATES=0 instance.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int WS = 2;

  typedef struct {
    int          id;
    logic        isFault;
    logic        isLoad;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdat;
    logic [31:0] expRd;
    int          acceptCyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] byteAddr, wd;
  logic [2:0]  funct3;
  logic        mwr, mrd;
  logic [31:0] rdOut, ramWd, ramRd;
  logic        busy, rdy, fault, ramWe, ramRe;
  logic [9:0]  ramAddr;
  logic [3:0]  ramBe;

  logic        mrd0;
  logic [31:0] rd0, ram0Wd, ram0Rd;
  logic        busy0, rdy0, fault0, ram0We, ram0Re;
  logic [9:0]  ram0Addr;
  logic [3:0]  ram0Be;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int txnId = 0;

  exp_t sbQ[$];
  logic        rdPending = 1'b0;
  logic [31:0] rdExpect;
  int          rdId;

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(WS)) dut (
    .clk_i(clk), .reset_i(reset), .byte_addr_i(byteAddr), .funct3_i(funct3), .wd_i(wd),
    .mwr_i(mwr), .mrd_i(mrd), .rd_o(rdOut), .mem_busy_o(busy), .mem_rdy_o(rdy),
    .fault_o(fault), .ram_addr_o(ramAddr), .ram_wd_o(ramWd), .ram_be_o(ramBe),
    .ram_we_o(ramWe), .ram_re_o(ramRe), .ram_rd_i(ramRd)
  );

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .byte_addr_i(32'h0000_0100), .funct3_i(3'b010),
    .wd_i(32'h0), .mwr_i(1'b0), .mrd_i(mrd0), .rd_o(rd0), .mem_busy_o(busy0),
    .mem_rdy_o(rdy0), .fault_o(fault0), .ram_addr_o(ram0Addr), .ram_wd_o(ram0Wd),
    .ram_be_o(ram0Be), .ram_we_o(ram0We), .ram_re_o(ram0Re), .ram_rd_i(ram0Rd)
  );

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behavioural word RAM with byte enables; read data appears the cycle after the strobe.
  logic [31:0] ram [0:1023];
  logic        ramInit;
  always @(posedge clk) begin
    if (ramInit) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      ram[10'h040] <= 32'h1234_5678;
      ram[10'h080] <= 32'h80FF_7F01;
    end else begin
      if (ramRe) ramRd <= ram[ramAddr];
      if (ramWe)
        for (int b = 0; b < 4; b++)
          if (ramBe[b]) ram[ramAddr][8*b +: 8] <= ramWd[8*b +: 8];
    end
  end

  always @(posedge clk) if (ram0Re) ram0Rd <= 32'hCAFE_0000 | {22'h0, ram0Addr};

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: records RAM strobes and retires one scoreboard entry per mem_rdy_o pulse.
  int          reCount = 0;
  int          weCount = 0;
  int          strobeCyc = 0;
  logic [9:0]  strobeAddr;
  logic [3:0]  strobeBe;
  logic [31:0] strobeWd;

  initial begin
    forever begin
      @(negedge clk);
      if (rdPending) begin
        checkOutput($sformatf("t%0d_rd_o", rdId), rdOut, rdExpect);
        rdPending = 1'b0;
      end
      if (reset) begin
        reCount = 0;
        weCount = 0;
      end else begin
        if (ramRe | ramWe) begin
          if (ramRe) reCount++;
          if (ramWe) weCount++;
          strobeCyc  = cycleCount;
          strobeAddr = ramAddr;
          strobeBe   = ramBe;
          strobeWd   = ramWd;
        end
        if (rdy) begin
          if (sbQ.size() == 0) begin
            checkOutput("unexpected_rdy", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput($sformatf("t%0d_fault", e.id), {31'h0, fault}, {31'h0, e.isFault});
            checkOutput($sformatf("t%0d_busy", e.id), {31'h0, busy}, 32'd1);
            checkOutput($sformatf("t%0d_latency", e.id), cycleCount - e.acceptCyc + 1,
                        e.isFault ? 32'd1 : WS + 2);
            checkOutput($sformatf("t%0d_re_count", e.id), reCount,
                        (!e.isFault && e.isLoad) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t%0d_we_count", e.id), weCount,
                        (!e.isFault && !e.isLoad) ? 32'd1 : 32'd0);
            if (!e.isFault) begin
              checkOutput($sformatf("t%0d_strobe_lat", e.id), strobeCyc - e.acceptCyc + 1, WS + 1);
              checkOutput($sformatf("t%0d_ram_addr", e.id), {22'h0, strobeAddr}, {22'h0, e.addr});
              if (!e.isLoad) begin
                checkOutput($sformatf("t%0d_ram_be", e.id), {28'h0, strobeBe}, {28'h0, e.be});
                checkOutput($sformatf("t%0d_ram_wd", e.id), strobeWd, e.wdat);
              end
            end
            rdPending = 1'b1;
            rdExpect  = e.expRd;
            rdId      = e.id;
          end
          reCount = 0;
          weCount = 0;
        end
      end
    end
  end

  // Throughput monitor for the zero-wait-state instance.
  int ws0Prev = 0;
  int ws0Count = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && rdy0) begin
        if (ws0Count > 0) checkOutput("ws0_interval", cycleCount - ws0Prev, 32'd3);
        ws0Prev = cycleCount;
        ws0Count++;
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while ((sbQ.size() != 0 || rdPending) && n < 40);
    if (n >= 40) begin
      checkOutput("timeout", 32'd1, 32'd0);
      sbQ.delete();
      rdPending = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic rdReq, input logic wrReq, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic expFault, input logic [3:0] expBe,
                               input logic [31:0] expWd, input logic [31:0] expRd);
    exp_t e;
    @(posedge clk); #2;
    mrd = rdReq; mwr = wrReq; funct3 = f3; byteAddr = addr; wd = data;
    @(posedge clk); #1;
    e.id        = txnId;
    e.isFault   = expFault;
    e.isLoad    = !wrReq;
    e.addr      = addr[11:2];
    e.be        = expBe;
    e.wdat      = expWd;
    e.expRd     = expRd;
    e.acceptCyc = cycleCount;
    mrd = 1'b0; mwr = 1'b0;
    sbQ.push_back(e);
    txnId++;
    waitIdle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; ramInit = 1'b1;
    mrd = 1'b0; mwr = 1'b0; mrd0 = 1'b0; funct3 = 3'b000; byteAddr = 32'h0; wd = 32'h0;
    #12;
    checkOutput("reset_rd_o", rdOut, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_rdy", {31'h0, rdy}, 32'h0);
    checkOutput("reset_fault", {31'h0, fault}, 32'h0);
    checkOutput("reset_ram_addr", {22'h0, ramAddr}, 32'h0);
    checkOutput("reset_ram_wd", ramWd, 32'h0);
    checkOutput("reset_ram_be", {28'h0, ramBe}, 32'h0);
    checkOutput("reset_ram_we", {31'h0, ramWe}, 32'h0);
    checkOutput("reset_ram_re", {31'h0, ramRe}, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0; ramInit = 1'b0;

    @(posedge clk); #2;
    mrd0 = 1'b1;
    repeat (10) @(posedge clk);
    #2 mrd0 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checkOutput("ws0_count", {31'h0, ws0Count >= 3}, 32'd1);
    checkOutput("ws0_rd_o", rd0, 32'hCAFE_0040);

    //            rd    wr    f3      addr          wd            flt   be       ramWd         rd_o after
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h1234_5678);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0,        1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0000_0080);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0,        1'b0, 4'b0000, 32'h0,        32'hFFFF_80FF);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_0200, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0000_7F01);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0105, 32'hAABB_CCDD, 1'b0, 4'b0010, 32'hDDDD_DDDD, 32'h0000_7F01);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0106, 32'hAABB_CCDD, 1'b0, 4'b1100, 32'hCCDD_CCDD, 32'h0000_7F01);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        1'b0, 4'b0000, 32'h0,        32'hCCDD_DD00);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,        1'b1, 4'b0000, 32'h0,        32'hCCDD_DD00);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h1111,     1'b1, 4'b0000, 32'h0,        32'hCCDD_DD00);
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        1'b1, 4'b0000, 32'h0,        32'hCCDD_DD00);
    applyStimulus(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h22,       1'b1, 4'b0000, 32'h0,        32'hCCDD_DD00);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0108, 32'h5A5A_1234, 1'b0, 4'b1111, 32'h5A5A_1234, 32'hCCDD_DD00);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0108, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h5A5A_1234);

    // Reset while waiting: outputs collapse immediately and no completion follows.
    @(posedge clk); #2;
    mrd = 1'b1; funct3 = 3'b010; byteAddr = 32'h0000_0100;
    @(posedge clk); #1;
    mrd = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("rstWait_busy", {31'h0, busy}, 32'h0);
    checkOutput("rstWait_re", {31'h0, ramRe}, 32'h0);
    checkOutput("rstWait_rd_o", rdOut, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Reset in the strobe cycle: the read strobe must drop without a clock edge.
    @(posedge clk); #2;
    mrd = 1'b1; funct3 = 3'b010; byteAddr = 32'h0000_0200;
    @(posedge clk); #1;
    mrd = 1'b0;
    begin
      int n = 0;
      while (!ramRe && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
    end
    checkOutput("rstAccess_reached", {31'h0, ramRe}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstAccess_re", {31'h0, ramRe}, 32'h0);
    checkOutput("rstAccess_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (6) @(posedge clk);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h80FF_7F01);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
